// File: rtl/hough_vote_engine.sv
// rtl/hough_vote_engine.sv - Hough line voter: scans an ROI edge map, votes into a THETAS x RHOS RAM, streams bins out
// Optional build macro: HOUGH_THRESH_EN (emit only bins with count >= VOTE_THRESHOLD; lower bins are cleared silently)
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   start               : begin a frame (sampled in IDLE only)
//   in_rd_en/in_empty/in_dout : first-word-fall-through input FIFO, pixel popped when in_rd_en
//   out_wr_en/out_full/out_dout/out_theta/out_rho : output FIFO push of one bin and its coordinates
//   busy                : high whenever not IDLE
//   dropped             : saturating count of votes whose rho bin fell outside 0..RHOS-1 this frame
//   hough_done          : one-cycle pulse after the last bin of EMIT
module hough_vote_engine #(
    parameter int X_START        = 0,
    parameter int X_END          = 720,
    parameter int Y_START        = 0,
    parameter int Y_END          = 540,
    parameter int X_WIDTH        = 11,
    parameter int Y_WIDTH        = 11,
    parameter int THETAS         = 180,
    parameter int RHOS           = 1024,
    parameter int RHO_SHIFT      = 1,
    parameter int TRIG_FRAC      = 12,
    parameter int ACCUM_BITS     = 16,
    parameter int VOTE_THRESHOLD = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      in_rd_en,
    input  logic                      in_empty,
    input  logic [7:0]                in_dout,
    output logic                      out_wr_en,
    input  logic                      out_full,
    output logic [ACCUM_BITS-1:0]     out_dout,
    output logic [$clog2(THETAS)-1:0] out_theta,
    output logic [$clog2(RHOS)-1:0]   out_rho,
    output logic                      busy,
    output logic [15:0]               dropped,
    output logic                      hough_done
);
    localparam int TW     = $clog2(THETAS);
    localparam int RW     = $clog2(RHOS);
    localparam int AW     = TW + RW;
    localparam int DEPTH  = THETAS * RHOS;
    localparam int TRIG_W = TRIG_FRAC + 2;
    localparam int PW     = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + TRIG_W + 2;
    localparam logic [ACCUM_BITS-1:0] ACC_MAX = {ACCUM_BITS{1'b1}};

    // cos(n*pi/d) rounded to TRIG_FRAC bits. Folding into the first quadrant keeps
    // cos/sin pairs exactly symmetric, and sin is taken as cos of the complement so
    // equal-magnitude entries (e.g. 45/135 deg) come out bit-identical.
    function automatic longint cos_fix(input longint n_in, input longint d);
        longint n, x, x2, term, sum, mag;
        bit neg;
        n   = (n_in < 0) ? -n_in : n_in;
        neg = 1'b0;
        if (64'sd2 * n > d) begin
            n   = d - n;
            neg = 1'b1;
        end
        x    = (n * 64'sd843314857) / d;   // pi * 2^28
        x2   = (x * x) >>> 28;
        term = 64'sd1 <<< 28;
        sum  = term;
        for (longint k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 28) / ((64'sd2 * k - 64'sd1) * (64'sd2 * k));
            sum  = sum + term;
        end
        mag = (sum + (64'sd1 <<< (27 - TRIG_FRAC))) >>> (28 - TRIG_FRAC);
        return neg ? -mag : mag;
    endfunction

    logic signed [TRIG_W-1:0] cos_rom [THETAS];
    logic signed [TRIG_W-1:0] sin_rom [THETAS];
    for (genvar g = 0; g < THETAS; g++) begin : g_trig
        localparam longint C = cos_fix(longint'(2 * g), longint'(2 * THETAS));
        localparam longint S = cos_fix(longint'(THETAS - 2 * g), longint'(2 * THETAS));
        assign cos_rom[g] = TRIG_W'(C);
        assign sin_rom[g] = TRIG_W'(S);
    end

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_VOTE, S_DRAIN, S_EMIT} state_t;
    state_t state, state_next;

    logic [ACCUM_BITS-1:0] acc [DEPTH];

    logic                  dirty, last_px;
    logic [X_WIDTH-1:0]    x, px;
    logic [Y_WIDTH-1:0]    y, py;
    logic [TW-1:0]         vtheta, sw_theta;
    logic [RW-1:0]         sw_rho;
    logic [1:0]            drain_cnt;
    logic                  s1_valid, s2_valid;
    logic [AW-1:0]         s1_addr, s2_addr;
    logic [ACCUM_BITS-1:0] s2_data, s2_inc;

    logic signed [PW-1:0]  xs, ys, cs, ss, rho, bin_s;
    logic                  in_range, issue, pop, x_last, y_last, sweep_last, sweeping;
    logic                  emit_sel, emit_step;
    logic [AW-1:0]         issue_addr, emit_addr;
    logic [ACCUM_BITS-1:0] emit_val;

    // Stage 1: rho for the current (pixel, theta) and its bin
    always_comb begin
        xs       = {{(PW - X_WIDTH){1'b0}}, px};
        ys       = {{(PW - Y_WIDTH){1'b0}}, py};
        cs       = {{(PW - TRIG_W){cos_rom[vtheta][TRIG_W-1]}}, cos_rom[vtheta]};
        ss       = {{(PW - TRIG_W){sin_rom[vtheta][TRIG_W-1]}}, sin_rom[vtheta]};
        rho      = (xs * cs + ys * ss) >>> TRIG_FRAC;
        bin_s    = (rho >>> RHO_SHIFT) + PW'(RHOS / 2);
        in_range = !bin_s[PW-1] && (bin_s < PW'(RHOS));
        issue_addr = {vtheta, bin_s[RW-1:0]};
    end

    assign issue      = (state == S_VOTE);
    assign pop        = (state == S_SCAN) && !in_empty;
    assign x_last     = (x == X_WIDTH'(X_END - 1));
    assign y_last     = (y == Y_WIDTH'(Y_END - 1));
    assign emit_addr  = {sw_theta, sw_rho};
    assign emit_val   = acc[emit_addr];
    assign sweep_last = (sw_theta == TW'(THETAS - 1)) && (sw_rho == RW'(RHOS - 1));
    assign s2_inc     = (s2_data == ACC_MAX) ? s2_data : s2_data + 1'b1;

`ifdef HOUGH_THRESH_EN
    assign emit_sel = (int'(emit_val) >= VOTE_THRESHOLD);
`else
    logic unused_thr;
    assign unused_thr = ^32'(VOTE_THRESHOLD);
    assign emit_sel   = 1'b1;
`endif

    // A bin is retired when it is pushed, or (threshold build) when it is below threshold
    assign emit_step = (state == S_EMIT) && (!emit_sel || !out_full);
    assign sweeping  = (state == S_CLEAR) || emit_step;

    assign in_rd_en  = pop;
    assign out_wr_en = (state == S_EMIT) && emit_sel && !out_full;
    assign out_dout  = (state == S_EMIT) ? emit_val : '0;
    assign out_theta = (state == S_EMIT) ? sw_theta : '0;
    assign out_rho   = (state == S_EMIT) ? sw_rho : '0;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = dirty ? S_CLEAR : S_SCAN;
            S_CLEAR: if (sweep_last) state_next = S_SCAN;
            S_SCAN:  if (pop) begin
                         if (in_dout != 8'd0)       state_next = S_VOTE;
                         else if (x_last && y_last) state_next = S_DRAIN;
                     end
            S_VOTE:  if (vtheta == TW'(THETAS - 1)) state_next = last_px ? S_DRAIN : S_SCAN;
            S_DRAIN: if (drain_cnt == 2'd2) state_next = S_EMIT;
            S_EMIT:  if (emit_step && sweep_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Accumulator: no reset; the dirty flag forces a CLEAR sweep instead
    always_ff @(posedge clock) begin
        if (sweeping)
            acc[emit_addr] <= '0;
        else if (s2_valid)
            acc[s2_addr] <= s2_inc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            dirty      <= 1'b1;
            x          <= X_WIDTH'(X_START);
            y          <= Y_WIDTH'(Y_START);
            px         <= '0;
            py         <= '0;
            last_px    <= 1'b0;
            vtheta     <= '0;
            sw_theta   <= '0;
            sw_rho     <= '0;
            drain_cnt  <= '0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s2_valid   <= 1'b0;
            s2_addr    <= '0;
            s2_data    <= '0;
            dropped    <= '0;
            hough_done <= 1'b0;
        end else begin
            state      <= state_next;
            hough_done <= emit_step && sweep_last;
            drain_cnt  <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            // Stages 2/3 of the vote pipeline; the stage-3 write is in the RAM block
            s1_valid <= issue && in_range;
            s1_addr  <= issue_addr;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_data  <= acc[s1_addr];

            if (state == S_IDLE && start) begin
                x       <= X_WIDTH'(X_START);
                y       <= Y_WIDTH'(Y_START);
                dropped <= '0;
            end else if (issue && !in_range && dropped != 16'hFFFF) begin
                dropped <= dropped + 16'd1;
            end

            if (pop) begin
                px      <= x;
                py      <= y;
                last_px <= x_last && y_last;
                vtheta  <= '0;
                if (x_last) begin
                    x <= X_WIDTH'(X_START);
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else if (issue) begin
                vtheta <= vtheta + 1'b1;
            end

            if (sweeping) begin
                if (sweep_last) begin
                    sw_theta <= '0;
                    sw_rho   <= '0;
                end else if (sw_rho == RW'(RHOS - 1)) begin
                    sw_rho   <= '0;
                    sw_theta <= sw_theta + 1'b1;
                end else begin
                    sw_rho <= sw_rho + 1'b1;
                end
            end

            if (state == S_CLEAR && sweep_last)
                dirty <= 1'b0;
        end
    end
endmodule
